// File: rtl/uart_clk_ctrl.sv
// UART baud tick generator: RX oversample strobe every R cycles, TX bit strobe every R*P cycles.
// Ticks are decoded from registers only; prescale changes are applied at bit boundaries or while idle.
module uart_clk_ctrl #(
  parameter int DIV_RATIO_WIDTH = 8
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_en,
  input  logic [5:0]                 i_prescale,
  output logic                       o_rx_tick,
  output logic                       o_tx_tick,
  output logic [DIV_RATIO_WIDTH-1:0] o_ratio,
  output logic                       o_cfg_upd,
  output logic                       o_cfg_err
);

  localparam logic [DIV_RATIO_WIDTH-1:0] RATIO_ONE = DIV_RATIO_WIDTH'(1);

  logic                       en_q;
  logic [DIV_RATIO_WIDTH-1:0] rx_cnt;
  logic [5:0]                 tx_cnt;
  logic [5:0]                 raw_q;
  logic [DIV_RATIO_WIDTH-1:0] ratio_q;
  logic [5:0]                 psc_q;
  logic                       err_q;
  logic                       upd_q;

  logic [DIV_RATIO_WIDTH-1:0] map_ratio;
  logic [5:0]                 map_psc;
  logic                       map_err;
  logic                       pending;
  logic                       apply;

  // Every legal setting keeps R*P at 32; illegal values fall back to the 32x setting.
  always_comb begin
    map_ratio = RATIO_ONE;
    map_psc   = 6'd32;
    map_err   = 1'b0;
    case (i_prescale)
      6'd32: ;
      6'd16: begin
        map_ratio = DIV_RATIO_WIDTH'(2);
        map_psc   = 6'd16;
      end
      6'd8: begin
        map_ratio = DIV_RATIO_WIDTH'(4);
        map_psc   = 6'd8;
      end
      default: map_err = 1'b1;
    endcase
  end

  assign o_rx_tick = en_q && (rx_cnt == ratio_q - RATIO_ONE);
  assign o_tx_tick = o_rx_tick && (tx_cnt == psc_q - 6'd1);

  assign pending = (i_prescale != raw_q);
  assign apply   = pending && (o_tx_tick || !en_q);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      en_q    <= 1'b0;
      rx_cnt  <= '0;
      tx_cnt  <= '0;
      raw_q   <= 6'd32;
      ratio_q <= RATIO_ONE;
      psc_q   <= 6'd32;
      err_q   <= 1'b0;
      upd_q   <= 1'b0;
    end else begin
      en_q  <= i_en;
      upd_q <= 1'b0;
      if (apply) begin
        raw_q   <= i_prescale;
        ratio_q <= map_ratio;
        psc_q   <= map_psc;
        err_q   <= map_err;
        upd_q   <= 1'b1;
        rx_cnt  <= '0;
        tx_cnt  <= '0;
      end else if (!en_q) begin
        rx_cnt <= '0;
        tx_cnt <= '0;
      end else begin
        rx_cnt <= o_rx_tick ? '0 : rx_cnt + RATIO_ONE;
        if (o_rx_tick) begin
          tx_cnt <= o_tx_tick ? 6'd0 : tx_cnt + 6'd1;
        end
      end
    end
  end

  assign o_ratio   = ratio_q;
  assign o_cfg_upd = upd_q;
  assign o_cfg_err = err_q;

endmodule

// File: tb/tb_uart_clk_ctrl.sv
// Randomized bench for uart_clk_ctrl: a phase-count reference model predicts every cycle's outputs
// into a queue; a negedge monitor pops and compares.
module tb_uart_clk_ctrl;

  logic       i_clk = 1'b0;
  logic       i_rst_n;
  logic       i_en;
  logic [5:0] i_prescale;
  logic       o_rx_tick;
  logic       o_tx_tick;
  logic [7:0] o_ratio;
  logic       o_cfg_upd;
  logic       o_cfg_err;

  uart_clk_ctrl #(.DIV_RATIO_WIDTH(8)) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_en       (i_en),
    .i_prescale (i_prescale),
    .o_rx_tick  (o_rx_tick),
    .o_tx_tick  (o_tx_tick),
    .o_ratio    (o_ratio),
    .o_cfg_upd  (o_cfg_upd),
    .o_cfg_err  (o_cfg_err)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic       rx;
    logic       tx;
    logic [7:0] ratio;
    logic       upd;
    logic       err;
  } obs_t;

  obs_t exp_q[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   cyc_no     = 0;

  // Reference model: m_run counts enabled edges since the last restart point
  // (idle edge, apply edge or reset); ticks follow from modular arithmetic on it.
  bit       m_en;
  int       m_run;
  int       m_r;
  int       m_p;
  logic [5:0] m_raw;
  bit       m_err;
  bit       m_upd;

  task automatic map_cfg(input logic [5:0] ps, output int r, output int p, output bit err);
    err = 1'b0;
    if (ps == 6'd32) begin r = 1; p = 32; end
    else if (ps == 6'd16) begin r = 2; p = 16; end
    else if (ps == 6'd8) begin r = 4; p = 8; end
    else begin r = 1; p = 32; err = 1'b1; end
  endtask

  function automatic obs_t model_obs();
    obs_t o;
    o.rx    = m_en && ((m_run % m_r) == m_r - 1);
    o.tx    = m_en && ((m_run % (m_r * m_p)) == m_r * m_p - 1);
    o.ratio = 8'(m_r);
    o.upd   = m_upd;
    o.err   = m_err;
    return o;
  endfunction

  task automatic model_reset();
    m_en = 0; m_run = 0; m_r = 1; m_p = 32; m_raw = 6'd32; m_err = 0; m_upd = 0;
  endtask

  task automatic model_edge(input logic en_in, input logic [5:0] ps_in);
    obs_t now;
    int r, p;
    bit e;
    now = model_obs();
    if ((ps_in != m_raw) && (now.tx || !m_en)) begin
      map_cfg(ps_in, r, p, e);
      m_r = r; m_p = p; m_err = e; m_raw = ps_in;
      m_run = 0;
      m_upd = 1;
    end else begin
      m_upd = 0;
      if (!m_en) m_run = 0;
      else m_run++;
    end
    m_en = en_in;
  endtask

  // One clock: model the edge with the inputs the DUT just sampled, drive the next inputs,
  // then queue the prediction for the cycle now in progress.
  task automatic cyc(input logic en, input logic [5:0] ps, input logic rst_n);
    @(posedge i_clk);
    #1;
    if (i_rst_n) model_edge(i_en, i_prescale);
    i_en       = en;
    i_prescale = ps;
    i_rst_n    = rst_n;
    if (!rst_n) model_reset();
    #1;
    exp_q.push_back(model_obs());
  endtask

  task automatic run(input int n, input logic en, input logic [5:0] ps);
    for (int k = 0; k < n; k++) cyc(en, ps, 1'b1);
  endtask

  always @(negedge i_clk) begin
    if (exp_q.size() > 0) begin
      obs_t e, g;
      e = exp_q.pop_front();
      g = '{rx: o_rx_tick, tx: o_tx_tick, ratio: o_ratio, upd: o_cfg_upd, err: o_cfg_err};
      cyc_no++;
      compared++;
      if (g !== e) begin
        mismatched++;
        $display("FAIL cycle_%0d outputs: got rx=%b tx=%b ratio=%0d upd=%b err=%b, want rx=%b tx=%b ratio=%0d upd=%b err=%b",
                 cyc_no, g.rx, g.tx, g.ratio, g.upd, g.err, e.rx, e.tx, e.ratio, e.upd, e.err);
      end
    end
  end

  initial begin
    logic       en;
    logic [5:0] ps;
    logic       rst;
    i_rst_n    = 1'b0;
    i_en       = 1'b0;
    i_prescale = 6'd32;
    model_reset();

    // Reset state, then 32x free run.
    cyc(1'b0, 6'd32, 1'b0);
    cyc(1'b0, 6'd32, 1'b0);
    run(3, 1'b0, 6'd32);
    run(80, 1'b1, 6'd32);

    // Reconfigure to 8 while idle, then run.
    run(5, 1'b0, 6'd8);
    run(80, 1'b1, 6'd8);

    // Move to 16, then change to 8 mid-bit.
    run(70, 1'b1, 6'd16);
    run(13, 1'b1, 6'd16);
    run(80, 1'b1, 6'd8);

    // Illegal prescale, then restore a legal one.
    run(80, 1'b1, 6'd20);
    run(80, 1'b1, 6'd16);

    // Glitch 32 -> 8 -> 32 within a bit.
    run(70, 1'b1, 6'd32);
    run(5, 1'b1, 6'd32);
    run(3, 1'b1, 6'd8);
    run(60, 1'b1, 6'd32);

    // Enable drop mid-bit, then re-enable.
    run(12, 1'b1, 6'd32);
    run(4, 1'b0, 6'd32);
    run(70, 1'b1, 6'd32);

    // Reset pulse mid-bit with a configuration pending.
    run(11, 1'b1, 6'd16);
    cyc(1'b1, 6'd16, 1'b0);
    cyc(1'b1, 6'd16, 1'b0);
    run(80, 1'b1, 6'd16);

    // Randomized traffic.
    en = 1'b1;
    ps = 6'd16;
    for (int k = 0; k < 3000; k++) begin
      rst = 1'b1;
      if ($urandom_range(0, 59) == 0) en = ~en;
      if ($urandom_range(0, 39) == 0) begin
        case ($urandom_range(0, 4))
          0: ps = 6'd8;
          1: ps = 6'd16;
          2: ps = 6'd32;
          3: ps = 6'd32;
          default: ps = 6'($urandom_range(0, 63));
        endcase
      end
      if ($urandom_range(0, 499) == 0) rst = 1'b0;
      cyc(en, ps, rst);
    end

    @(negedge i_clk);
    #1;
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: got %0d predictions left unchecked, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
